pipe_stage_reg: RTL and testbench

- Parametrised pipeline stage register that generalises the fixed M→W control-register pairs into one reusable block.
- Carries a WIDTH-bit payload with a valid/ready handshake, an optional 1-entry skid buffer, and synchronous flush.
- Outputs NOP_VALUE whenever empty, so killed or absent beats never assert side-effect controls such as RegWrite.
- Sits between any two pipeline stages (F/D, D/E, E/M, M/W); the hazard unit drives flush and back-pressure.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_stage_reg_if.sv | 12 +
 rtl/pipe_slot.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 tb/tb_pipe_stage_reg.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for pipeline stage registers: per-boundary control payloads,
// their bubble (NOP) encodings, and the occupancy state of a stage register.
package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } ctrl_mw_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } ctrl_em_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_de_t;

  localparam ctrl_mw_t CTRL_MW_NOP = '0;
  localparam ctrl_em_t CTRL_EM_NOP = '0;
  localparam ctrl_de_t CTRL_DE_NOP = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream carrying one WIDTH-bit payload; master drives the beat,
// slave answers with ready.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 3
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One valid+data holding register; clear returns it to the NOP payload and
// wins over load so a flush always empties the slot.
module pipe_slot #(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
      data_d  = NOP_VALUE;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= NOP_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Reusable pipeline stage register: valid/ready payload hand-off with optional
// skid slot, synchronous flush, NOP output when empty and a stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter bit               SKID      = 1'b1,
  parameter int               CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipe_stage_reg_if.slave       in_if,
  pipe_stage_reg_if.master      out_if,
  input  logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic             mv, sv;
  logic [WIDTH-1:0] md, sd;
  logic             acc, take;
  logic             main_load, main_clear, skid_load, skid_clear;
  logic [WIDTH-1:0] main_src;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  stage_state_e     state;

  // Without a skid slot, in_ready must look through to out_ready so a full
  // stage can still accept in the same cycle it is drained.
  assign in_if.ready = SKID ? ~sv : (~mv | out_if.ready);
  assign acc         = in_if.valid & in_if.ready;
  assign take        = mv & out_if.ready;

  // Occupancy lives in the slot valid bits; the enum is a decoded view of them.
  assign state = sv ? TWO : (mv ? ONE : EMPTY);

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    main_src   = in_if.data;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: main_load = acc;
        ONE: begin
          if (acc && take)  main_load  = 1'b1;
          else if (acc)     skid_load  = 1'b1;
          else if (take)    main_clear = 1'b1;
        end
        TWO: begin
          if (take) begin
            main_load  = 1'b1;
            main_src   = sd;
            skid_clear = 1'b1;
          end
        end
        default: main_clear = 1'b1;
      endcase
    end
  end

  pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_main (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (main_load),
    .clear     (main_clear),
    .load_data (main_src),
    .valid     (mv),
    .data      (md)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (in_if.data),
        .valid     (sv),
        .data      (sd)
      );
    end else begin : g_no_skid
      assign sv = 1'b0;
      assign sd = NOP_VALUE;
    end
  endgenerate

  assign out_if.valid = mv;
  assign out_if.data  = md;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (mv && !out_if.ready && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Checks a skid (index 1) and a no-skid, 4-bit-counter (index 0) stage register
// against a queue-based model of the stage's occupancy and stall count.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int               WIDTH = 3;
  localparam logic [WIDTH-1:0] NOP   = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.WIDTH(WIDTH)) in0 (), out0 (), in1 (), out1 ();

  logic             iv   [2];
  logic [WIDTH-1:0] idt  [2];
  logic             ordy [2];
  logic             fl   [2];
  logic [3:0]       sc0;
  logic [15:0]      sc1;

  assign in0.valid  = iv[0];
  assign in0.data   = idt[0];
  assign out0.ready = ordy[0];
  assign in1.valid  = iv[1];
  assign in1.data   = idt[1];
  assign out1.ready = ordy[1];

  pipe_stage_reg #(.WIDTH(WIDTH), .NOP_VALUE(NOP), .SKID(1'b0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_if(in0), .out_if(out0), .flush(fl[0]), .stall_cnt(sc0)
  );

  pipe_stage_reg #(.WIDTH(WIDTH), .NOP_VALUE(NOP), .SKID(1'b1), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_if(in1), .out_if(out1), .flush(fl[1]), .stall_cnt(sc1)
  );

  // Model: each stage is a FIFO of held beats (capacity 2 with skid, 1 without).
  logic [WIDTH-1:0] mq [2][$];
  int               cnt [2];
  int               cnt_max [2];
  bit               last_acc [2];
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_ready(input int k);
    if (k == 1) return mq[k].size() < 2;
    return (mq[k].size() == 0) || ordy[k];
  endfunction

  task automatic checkOutput(input int k);
    bit               ev;
    logic [WIDTH-1:0] ed;
    ev = mq[k].size() > 0;
    ed = ev ? mq[k][0] : NOP;
    chk($sformatf("out_valid%0d", k), 32'(k == 1 ? out1.valid : out0.valid), 32'(ev));
    chk($sformatf("out_data%0d", k),  32'(k == 1 ? out1.data  : out0.data),  32'(ed));
    chk($sformatf("in_ready%0d", k),  32'(k == 1 ? in1.ready  : in0.ready),  32'(exp_ready(k)));
    chk($sformatf("stall_cnt%0d", k), (k == 1) ? 32'(sc1) : 32'(sc0), 32'(cnt[k]));
  endtask

  task automatic advance_model(input int k);
    bit take, acc;
    take = (mq[k].size() > 0) && ordy[k];
    acc  = iv[k] && exp_ready(k);
    if (mq[k].size() > 0 && !ordy[k] && cnt[k] < cnt_max[k]) cnt[k]++;
    last_acc[k] = acc;
    if (fl[k]) mq[k].delete();
    else begin
      if (take) void'(mq[k].pop_front());
      if (acc)  mq[k].push_back(idt[k]);
    end
  endtask

  // One clock cycle: check both stages mid-cycle, then step the model.
  task automatic applyStimulus();
    @(negedge clk);
    for (int k = 0; k < 2; k++) checkOutput(k);
    for (int k = 0; k < 2; k++) advance_model(k);
    @(posedge clk);
    #1;
  endtask

  task automatic random_drive(input int k);
    if (!iv[k] || last_acc[k]) begin
      iv[k]  = ($urandom_range(0, 3) != 0);
      idt[k] = WIDTH'($urandom);
    end
    ordy[k] = ($urandom_range(0, 2) != 0);
    fl[k]   = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; idt[k] = '0; ordy[k] = 1'b0; fl[k] = 1'b0;
      cnt[k] = 0; last_acc[k] = 1'b0;
    end
    cnt_max[0] = 15;
    cnt_max[1] = 65535;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Async reset while holding 3'b101
    iv[1] = 1'b1; idt[1] = 3'b101; applyStimulus();
    iv[1] = 1'b0; applyStimulus();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out1.valid), 32'd0);
    chk("rst_out_data",  32'(out1.data),  32'd0);
    chk("rst_in_ready",  32'(in1.ready),  32'd1);
    chk("rst_stall_cnt", 32'(sc1),        32'd0);
    for (int k = 0; k < 2; k++) begin mq[k].delete(); cnt[k] = 0; last_acc[k] = 1'b0; end
    rst_n = 1'b1;

    // Streaming through the skid stage
    ordy[1] = 1'b1;
    for (int b = 1; b <= 4; b++) begin iv[1] = 1'b1; idt[1] = WIDTH'(b); applyStimulus(); end
    iv[1] = 1'b0;
    repeat (2) applyStimulus();

    // Back-pressure: 5 in main, 6 in skid, 7 waits upstream
    ordy[1] = 1'b0; iv[1] = 1'b1;
    idt[1] = 3'd5; applyStimulus();
    idt[1] = 3'd6; applyStimulus();
    idt[1] = 3'd7; applyStimulus();
    applyStimulus();
    chk("bp_in_ready",  32'(in1.ready), 32'd0);
    chk("bp_stall_cnt", 32'(sc1),       32'd3);
    ordy[1] = 1'b1;
    repeat (6) begin applyStimulus(); if (last_acc[1]) iv[1] = 1'b0; end

    // Flush while full with 7 offered
    ordy[1] = 1'b0; iv[1] = 1'b1;
    idt[1] = 3'd5; applyStimulus();
    idt[1] = 3'd6; applyStimulus();
    idt[1] = 3'd7; fl[1] = 1'b1; applyStimulus();
    fl[1] = 1'b0; iv[1] = 1'b0;
    chk("flush_out_valid", 32'(out1.valid), 32'd0);
    chk("flush_out_data",  32'(out1.data),  32'd0);
    chk("flush_in_ready",  32'(in1.ready),  32'd1);
    ordy[1] = 1'b1;
    repeat (2) applyStimulus();

    // No-skid stage: ready follows out_ready combinationally
    ordy[0] = 1'b0; iv[0] = 1'b1;
    idt[0] = 3'd3; applyStimulus();
    idt[0] = 3'd4; applyStimulus();
    chk("ns_in_ready_low", 32'(in0.ready), 32'd0);
    ordy[0] = 1'b1;
    #1;
    chk("ns_in_ready_high", 32'(in0.ready), 32'd1);
    applyStimulus();
    iv[0] = 1'b0;
    chk("ns_out_data", 32'(out0.data), 32'd4);
    repeat (2) applyStimulus();

    // 4-bit stall counter saturation, then flush leaves it alone
    ordy[0] = 1'b0; iv[0] = 1'b1; idt[0] = 3'd6; applyStimulus();
    iv[0] = 1'b0;
    repeat (20) applyStimulus();
    chk("sat_stall_cnt", 32'(sc0), 32'd15);
    fl[0] = 1'b1; applyStimulus();
    fl[0] = 1'b0;
    chk("sat_after_flush", 32'(sc0), 32'd15);
    chk("sat_flush_valid", 32'(out0.valid), 32'd0);

    // Randomized traffic on both stages
    repeat (400) begin
      random_drive(0);
      random_drive(1);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
